// File: rtl/serial_frame_rx_if.sv
// Serial frame receiver bus: bit stream in, byte handshake and frame status out.
// master = stream source / byte consumer, slave = receiver.
interface serial_frame_rx_if;
   logic       din;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ready;
   logic       frame_active;
   logic       frame_ok;
   logic       frame_err;
   logic       overflow;

   modport master (
      output din, dout_ready,
      input  dout, dout_valid, frame_active, frame_ok, frame_err, overflow
   );
   modport slave (
      input  din, dout_ready,
      output dout, dout_valid, frame_active, frame_ok, frame_err, overflow
   );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync byte, emits payload bytes over a
// valid/ready handshake and verifies a trailing XOR check byte.
module serial_frame_rx #(
   parameter logic [7:0] SYNC_WORD     = 8'hA5,
   parameter int         PAYLOAD_BYTES = 4
) (
   input logic              clk,
   input logic              reset,
   serial_frame_rx_if.slave bus
);
   typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

   state_t     r_state;
   logic [7:0] r_sr;
   logic [3:0] r_hcnt;
   logic [2:0] r_bitcnt;
   logic [7:0] r_bytecnt;
   logic [7:0] r_xor;
   logic [7:0] r_dout;
   logic       r_dv;
   logic       r_active;
   logic       r_ok;
   logic       r_err;
   logic       r_ovf;

   logic [7:0] w_byte;
   assign w_byte = {r_sr[6:0], bus.din};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= HUNT;
         r_sr      <= 8'h00;
         r_hcnt    <= 4'd0;
         r_bitcnt  <= 3'd0;
         r_bytecnt <= 8'd0;
         r_xor     <= 8'h00;
         r_dout    <= 8'h00;
         r_dv      <= 1'b0;
         r_active  <= 1'b0;
         r_ok      <= 1'b0;
         r_err     <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_sr  <= w_byte;
         r_ok  <= 1'b0;
         r_err <= 1'b0;
         // a byte loaded later in this block overrides the clear
         if (r_dv && bus.dout_ready)
            r_dv <= 1'b0;

         case (r_state)
            HUNT: begin
               // hcnt >= 7 guarantees the match window holds only fresh bits
               if (r_hcnt >= 4'd7 && w_byte == SYNC_WORD) begin
                  r_state   <= PAYLOAD;
                  r_active  <= 1'b1;
                  r_bitcnt  <= 3'd0;
                  r_bytecnt <= 8'd0;
                  r_xor     <= 8'h00;
                  r_hcnt    <= 4'd0;
               end else if (r_hcnt != 4'd8) begin
                  r_hcnt <= r_hcnt + 4'd1;
               end
            end
            PAYLOAD: begin
               r_bitcnt <= r_bitcnt + 3'd1;
               if (r_bitcnt == 3'd7) begin
                  r_xor     <= r_xor ^ w_byte;
                  r_bytecnt <= r_bytecnt + 8'd1;
                  if (!r_dv || bus.dout_ready) begin
                     r_dout <= w_byte;
                     r_dv   <= 1'b1;
                  end else begin
                     r_ovf <= 1'b1;
                  end
                  if (r_bytecnt == 8'(PAYLOAD_BYTES - 1))
                     r_state <= CHECK;
               end
            end
            CHECK: begin
               r_bitcnt <= r_bitcnt + 3'd1;
               if (r_bitcnt == 3'd7) begin
                  if (w_byte == r_xor) r_ok  <= 1'b1;
                  else                 r_err <= 1'b1;
                  r_state  <= HUNT;
                  r_active <= 1'b0;
                  r_hcnt   <= 4'd0;
               end
            end
            default: begin
               r_state  <= HUNT;
               r_active <= 1'b0;
               r_hcnt   <= 4'd0;
            end
         endcase
      end
   end

   assign bus.dout         = r_dout;
   assign bus.dout_valid   = r_dv;
   assign bus.frame_active = r_active;
   assign bus.frame_ok     = r_ok;
   assign bus.frame_err    = r_err;
   assign bus.overflow     = r_ovf;
endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 8'hA5, the 8-bit frame sync pattern, MSB first.
REQ-002 SHALL have parameter PAYLOAD_BYTES, default 4, the payload bytes per frame; legal range 1..255.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port din  input  1  serial bit stream, one bit per clk, MSB first; driven by the upstream D flip-flop's dout.
REQ-006 SHALL have port dout  output  8  received payload byte.
REQ-007 SHALL have port dout_valid  output  1  dout holds an unconsumed byte.
REQ-008 SHALL have port dout_ready  input  1  consumer accepts dout when dout_valid is also high.
REQ-009 SHALL have port frame_active  output  1  high in PAYLOAD and CHECK states.
REQ-010 SHALL have port frame_ok  output  1  one-cycle pulse: frame check byte matched.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse: frame check byte mismatched.
REQ-012 SHALL have port overflow  output  1  sticky: a payload byte was discarded.

Function
REQ-013 SHALL shift din into an 8-bit register on every clk, except while reset is high: sr <= {sr[6:0], din}.
REQ-014 SHALL implement FSM states HUNT, PAYLOAD and CHECK.
REQ-015 HUNT: SHALL count the bits shifted since entering HUNT, saturating at 8.
REQ-016 HUNT: SHALL detect sync only when that count is at least 7 before the current bit and {sr[6:0], din} == SYNC_WORD; the next state is then PAYLOAD.
REQ-017 HUNT: the counter rule SHALL prevent a match on stale bits after reset or after a previous frame ends.
REQ-018 PAYLOAD: SHALL count bits 0..7; on the 8th bit, the assembled byte is {sr[6:0], din}.
REQ-019 PAYLOAD: on each assembled byte, SHALL XOR the byte into the running check and increment the byte count.
REQ-020 PAYLOAD: after byte PAYLOAD_BYTES is assembled, the next state SHALL be CHECK.
REQ-021 CHECK: SHALL collect 8 bits; on the 8th bit, compare {sr[6:0], din} with the running XOR.
REQ-022 CHECK: on the 8th bit, SHALL pulse frame_ok on equality or frame_err otherwise, for exactly one cycle, and return to HUNT.
REQ-023 SHALL clear the running XOR, the bit count and the byte count on sync detection.
REQ-024 Latency: a byte whose 8th bit is sampled at edge N SHALL appear on dout with dout_valid=1 immediately after edge N.
REQ-025 frame_ok/frame_err SHALL be asserted immediately after the edge sampling the last check bit.
REQ-026 Handshake: dout SHALL hold stable while dout_valid=1 and dout_ready=0.
REQ-027 Handshake: a transfer occurs on an edge where dout_valid=1 and dout_ready=1; dout_valid SHALL then clear unless a new byte loads on that same edge.
REQ-028 Simultaneous transfer and new byte: the new byte SHALL load and dout_valid SHALL stay 1; no overflow.
REQ-029 New byte while dout_valid=1 and dout_ready=0: the new byte SHALL be discarded, the old dout retained, and overflow set to 1.
REQ-030 A discarded byte SHALL still be XORed into the check and counted.
REQ-031 The check byte SHALL never be presented on dout.
REQ-032 frame_ok and frame_err SHALL never be high together.

Reset
REQ-033 While reset=1 at an edge, the block SHALL set state=HUNT, sr=0, all counters and the XOR to 0, dout=8'h00, dout_valid=0, frame_ok=0, frame_err=0, overflow=0, frame_active=0.
REQ-034 Reset mid-frame SHALL discard the partial frame; no frame_ok/frame_err pulse and no dout_valid for partial bytes.
REQ-035 After reset, sync detection SHALL require 8 fresh bits.

Verification
REQ-036 Good frame, dout_ready=1: bits A5 11 22 33 44 44 -> dout 11,22,33,44, one dout_valid cycle per byte, 8 cycles apart; one frame_ok pulse; frame_err=0, overflow=0.
REQ-037 Bad check: A5 11 22 33 44 45 -> four bytes delivered, one frame_err pulse, no frame_ok.
REQ-038 Backpressure: dout_ready=0 for the whole good frame -> dout stays 11, dout_valid=1, overflow=1 after byte 22; frame_ok still pulses (check computed over all four bytes).
REQ-039 Simultaneous transfer: dout_ready asserted only on the edge byte 22 completes -> 11 accepted, dout=22 with dout_valid held 1, overflow=0.
REQ-040 Reset mid-frame: reset pulsed after A5 11 and 4 bits of 22, then good frame sent -> no pulses from the aborted frame; the second frame yields frame_ok.
REQ-041 False sync: idle 0s, reset release, then stream 1010 0101 split across the reset boundary -> no sync until 8 post-reset bits equal A5; frame_active=0 until then.
